gnr_attractor_ctrl: RTL and testbench

//  Drives an array of N_NODES boolean-network nodes and reads their state back.
//  For each initial state accepted on a valid/ready stream, it loads the nodes,

---
 rtl/gnr_attractor_ctrl.sv | 108 ++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gnr_attractor_ctrl.sv
// Attractor-detection controller for a boolean-network node array (tortoise/hare stepping).
// Latency: accept -> LOAD (1) -> RUN (steps+1 cycles) -> REPORT; res_valid 2 cycles after the final pulse.
// Backpressure: init_ready only in IDLE with enable; REPORT holds res_* until res_ready.
module gnr_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               init_valid,
  output logic               init_ready,
  input  logic [N_NODES-1:0] init_data,
  output logic               node_reset,
  output logic [N_NODES-1:0] node_init,
  output logic               node_start_s0,
  output logic               node_start_s1,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_state,
  output logic [CNT_W-1:0]   res_steps,
  output logic               res_timeout,
  output logic               busy,
  output logic [CNT_W-1:0]   res_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_t;

  state_t             state, state_next;
  logic [N_NODES-1:0] init_reg;
  logic [CNT_W-1:0]   step_cnt;
  logic               is_match;
  logic               is_timeout;

  // The first pulse moves both copies, so equality only means something from two pulses on.
  assign is_match   = (step_cnt >= CNT_W'(2)) && (s0_vec == s1_vec);
  assign is_timeout = (step_cnt == CNT_W'(MAX_STEPS));

  // Next-state and pulse outputs; match wins over timeout on the same cycle.
  always_comb begin
    state_next    = state;
    init_ready    = 1'b0;
    node_reset    = 1'b0;
    node_init     = '0;
    node_start_s0 = 1'b0;
    node_start_s1 = 1'b0;
    res_valid     = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        init_ready = enable;
        if (init_valid && enable) state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        node_reset = 1'b1;
        node_init  = init_reg;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (is_match || is_timeout) begin
          state_next = REPORT;
        end else begin
          node_start_s0 = 1'b1;
          node_start_s1 = 1'b1;
        end
      end
      REPORT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus init capture, step counter, result capture and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      init_reg    <= '0;
      step_cnt    <= '0;
      res_state   <= '0;
      res_steps   <= '0;
      res_timeout <= 1'b0;
      res_count   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && init_valid && enable) init_reg <= init_data;
      if (state == LOAD) step_cnt <= '0;
      if (state == RUN) begin
        if (is_match || is_timeout) begin
          res_state   <= s1_vec;
          res_steps   <= step_cnt;
          res_timeout <= !is_match;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
      if (state == REPORT && res_ready) res_count <= res_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a 4-node behavioural node array.
// Two instances: default step limit, and a step limit of 5 for the timeout case.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_gnr_attractor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       res_ready = 1'b0;
  logic [3:0] init_data = '0;
  logic       net_rot = 1'b0;

  logic        a_valid = 1'b0, a_ready, a_nreset, a_st0, a_st1, a_rvalid, a_rto, a_busy;
  logic [3:0]  a_ninit, a_rstate;
  logic [15:0] a_rsteps, a_rcount;
  logic [3:0]  a_s0 = '0, a_s1 = '0;
  logic        a_pass = 1'b0;

  logic        b_valid = 1'b0, b_ready, b_nreset, b_st0, b_st1, b_rvalid, b_rto, b_busy;
  logic [3:0]  b_ninit, b_rstate;
  logic [15:0] b_rsteps, b_rcount;
  logic [3:0]  b_s0 = '0, b_s1 = '0;
  logic        b_pass = 1'b0;

  int errors = 0;
  int checks = 0;

  gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(1000)) dut_a (
    .clk(clk), .rst(rst), .enable(enable),
    .init_valid(a_valid), .init_ready(a_ready), .init_data(init_data),
    .node_reset(a_nreset), .node_init(a_ninit),
    .node_start_s0(a_st0), .node_start_s1(a_st1),
    .s0_vec(a_s0), .s1_vec(a_s1),
    .res_valid(a_rvalid), .res_ready(res_ready), .res_state(a_rstate),
    .res_steps(a_rsteps), .res_timeout(a_rto), .busy(a_busy), .res_count(a_rcount)
  );

  gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(5)) dut_b (
    .clk(clk), .rst(rst), .enable(enable),
    .init_valid(b_valid), .init_ready(b_ready), .init_data(init_data),
    .node_reset(b_nreset), .node_init(b_ninit),
    .node_start_s0(b_st0), .node_start_s1(b_st1),
    .s0_vec(b_s0), .s1_vec(b_s1),
    .res_valid(b_rvalid), .res_ready(res_ready), .res_state(b_rstate),
    .res_steps(b_rsteps), .res_timeout(b_rto), .busy(b_busy), .res_count(b_rcount)
  );

  // Network update rule: identity (fixed point) or rotate-left by one node.
  function automatic logic [3:0] nf(input logic [3:0] x, input logic rot);
    return rot ? {x[2:0], x[3]} : x;
  endfunction

  // Node array A: s1 steps every pulse, s0 steps on every second pulse starting with the first.
  always @(posedge clk) begin
    if (a_nreset) begin
      a_s0 <= a_ninit; a_s1 <= a_ninit; a_pass <= 1'b1;
    end else begin
      if (a_st1) a_s1 <= nf(a_s1, net_rot);
      if (a_st0) begin
        if (a_pass) a_s0 <= nf(a_s0, net_rot);
        a_pass <= ~a_pass;
      end
    end
  end

  // Node array B: same behaviour, attached to the short-limit instance.
  always @(posedge clk) begin
    if (b_nreset) begin
      b_s0 <= b_ninit; b_s1 <= b_ninit; b_pass <= 1'b1;
    end else begin
      if (b_st1) b_s1 <= nf(b_s1, net_rot);
      if (b_st0) begin
        if (b_pass) b_s0 <= nf(b_s0, net_rot);
        b_pass <= ~b_pass;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Snapshot of the LOAD cycle and first RUN cycle of the latest run on A.
  logic [3:0] ld_init;
  logic       ld_reset, ld_start, r1_start, r1_reset;

  // Offer init on A (enable must be high), then count falling edges until res_valid.
  task automatic run_a(input logic [3:0] init, input bit drop_en, output int lat);
    lat = -1;
    init_data = init;
    a_valid   = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_valid  = 1'b0;
        ld_reset = a_nreset;
        ld_init  = a_ninit;
        ld_start = a_st0 | a_st1;
      end
      if (n == 2) begin
        r1_start = a_st0 & a_st1;
        r1_reset = a_nreset;
        if (drop_en) enable = 1'b0;
      end
      if (a_rvalid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;

    repeat (3) @(negedge clk);
    check("rst_init_ready", a_ready, 0);
    check("rst_node_reset", a_nreset, 0);
    check("rst_node_init", a_ninit, 0);
    check("rst_start", {a_st0, a_st1}, 0);
    check("rst_res_valid", a_rvalid, 0);
    check("rst_res_fields", {a_rstate, a_rsteps, a_rto}, 0);
    check("rst_busy", a_busy, 0);
    check("rst_res_count", a_rcount, 0);
    rst    = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("idle_init_ready", a_ready, 1);

    // Fixed-point net: match as soon as comparing is allowed.
    net_rot = 1'b0;
    run_a(4'b1010, 1'b0, lat);
    check("fix_latency", lat, 5);
    check("fix_load_reset", ld_reset, 1);
    check("fix_load_init", ld_init, 4'b1010);
    check("fix_load_nostart", ld_start, 0);
    check("fix_run1_start", r1_start, 1);
    check("fix_run1_noreset", r1_reset, 0);
    check("fix_state", a_rstate, 4'b1010);
    check("fix_steps", a_rsteps, 2);
    check("fix_timeout", a_rto, 0);

    // Stall in REPORT for 10 cycles.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_rstate !== 4'b1010 || a_rsteps !== 16'd2 || a_rto !== 1'b0 || a_rvalid !== 1'b1) bad++;
      if (a_ready !== 1'b0 || a_st0 !== 1'b0 || a_st1 !== 1'b0 || a_nreset !== 1'b0) bad++;
      @(negedge clk);
    end
    check("hold_bad_cycles", bad, 0);
    check("hold_count", a_rcount, 0);
    handshake();
    check("hs_valid_drop", a_rvalid, 0);
    check("hs_count", a_rcount, 1);
    check("hs_idle", a_busy, 0);

    // Rotate-left net: period 4, tortoise/hare meet after 8 pulses.
    net_rot = 1'b1;
    run_a(4'b0001, 1'b0, lat);
    check("rot_latency", lat, 11);
    check("rot_state", a_rstate, 4'b0001);
    check("rot_steps", a_rsteps, 8);
    check("rot_timeout", a_rto, 0);
    handshake();
    check("rot_count", a_rcount, 2);

    // Short step limit: timeout at 5 pulses.
    init_data = 4'b0001;
    b_valid   = 1'b1;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) b_valid = 1'b0;
      if (b_rvalid) begin
        lat = n;
        break;
      end
    end
    check("to_latency", lat, 8);
    check("to_timeout", b_rto, 1);
    check("to_steps", b_rsteps, 5);
    check("to_state", b_rstate, 4'b0010);
    handshake();
    check("to_count", b_rcount, 1);

    // Reset on the third RUN cycle.
    init_data = 4'b0001;
    a_valid   = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) a_valid = 1'b0;
    end
    check("mid_run_pulsing", {a_st0, a_st1, a_busy}, 3'b111);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_pulses", {a_st0, a_st1, a_nreset}, 0);
    check("mid_rst_res", {a_rvalid, a_rstate, a_rsteps, a_rto}, 0);
    check("mid_rst_count", a_rcount, 0);
    check("mid_rst_ready", a_ready, 0);
    rst     = 1'b0;
    enable  = 1'b1;
    net_rot = 1'b0;
    run_a(4'b0110, 1'b0, lat);
    check("post_rst_latency", lat, 5);
    check("post_rst_state", a_rstate, 4'b0110);
    check("post_rst_steps", a_rsteps, 2);
    handshake();

    // enable low blocks accepts; a run in progress survives enable dropping.
    enable    = 1'b0;
    init_data = 4'b0011;
    a_valid   = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_ready !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    check("en_low_no_accept", bad, 0);
    enable = 1'b1;
    run_a(4'b0011, 1'b1, lat);
    check("en_drop_latency", lat, 5);
    check("en_drop_state", a_rstate, 4'b0011);
    check("en_drop_steps", a_rsteps, 2);
    handshake();
    check("b2b_count", a_rcount, 2);
    check("b2b_idle", {a_busy, a_ready}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
